// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   WORD_W        data word width (64)
//   BYTE_OFF      byte-offset bits inside a doubleword (3)
//   idx_t         word index carried through the write buffer (upper bits
//                 stay zero; only the low log2(DEPTH) bits are used)
//   wb_entry_t    write-buffer entry {index, data}
//   addr_to_index byte address -> word index, wrapped modulo DEPTH
package dmem_pkg;
  localparam int WORD_W    = 64;
  localparam int BYTE_OFF  = 3;
  localparam int IDX_MAX_W = WORD_W - BYTE_OFF;

  typedef logic [IDX_MAX_W-1:0] idx_t;

  typedef struct packed {
    idx_t              index;
    logic [WORD_W-1:0] data;
  } wb_entry_t;

  function automatic idx_t addr_to_index(input logic [WORD_W-1:0] addr,
                                         input int unsigned       idx_w);
    idx_t mask;
    mask = (idx_t'(1) << idx_w) - idx_t'(1);
    return idx_t'(addr >> BYTE_OFF) & mask;
  endfunction
endpackage

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-write FIFO with youngest-first lookup.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_entry  enqueue an entry at posedge
//   pop, pop_entry    dequeue the oldest entry at posedge (pop_entry is the
//                     current head, valid whenever count > 0)
//   count             occupancy, 0..WB_DEPTH
//   lookup_index      index to search for
//   hit, hit_data     youngest valid entry matching lookup_index
// Push and pop may happen on the same edge, including when full.
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int  WB_DEPTH = 4,
  localparam int PTR_W    = $clog2(WB_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         pop_entry,
  output logic [CNT_W-1:0]  count,
  input  idx_t              lookup_index,
  output logic              hit,
  output logic [WORD_W-1:0] hit_data
);

  wb_entry_t        entries [WB_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Entry storage needs no reset: validity is derived from count.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_entry = entries[rd_ptr];

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] pos;
    hit      = 1'b0;
    hit_data = '0;
    pos      = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      pos = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entries[pos].index == lookup_index)) begin
        hit      = 1'b1;
        hit_data = entries[pos].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: zero-latency data memory with a posted write buffer.
// Optional build macro: DMEM_STATS_EN adds rd_cnt/wr_cnt/fwd_cnt counters.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   memAddr         byte address (index = memAddr[log2(DEPTH)+2:3])
//   memWriteData    store data
//   MemWrite        store strobe, sampled at posedge
//   MemRead         load strobe
//   memReadData     combinational load data (buffer forwarding, then array)
//   flush           drain request
//   wb_count        write-buffer occupancy
//   wb_empty        wb_count == 0
//   mem_misaligned  sticky misaligned-access flag
//   proto_err       sticky MemRead && MemWrite flag
//   rd_cnt, wr_cnt, fwd_cnt  (DMEM_STATS_EN only) access counters
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int  DEPTH    = 32,
  parameter int  WB_DEPTH = 4,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(WB_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] memAddr,
  input  logic [WORD_W-1:0] memWriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [WORD_W-1:0] memReadData,
  input  logic              flush,
  output logic [CNT_W-1:0]  wb_count,
  output logic              wb_empty,
  output logic              mem_misaligned,
  output logic              proto_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  logic [WORD_W-1:0] mem_array [DEPTH];

  idx_t              index;
  logic              aligned;
  logic              push;
  logic              pop;
  logic              full;
  logic              bad_access;
  logic              hit;
  logic [WORD_W-1:0] hit_data;
  wb_entry_t         push_entry;
  wb_entry_t         pop_entry;

  assign index      = addr_to_index(memAddr, IDX_W);
  assign aligned    = (memAddr[BYTE_OFF-1:0] == '0);
  assign push       = MemWrite && aligned;
  assign full       = (wb_count == CNT_W'(WB_DEPTH));
  assign bad_access = ((MemRead || MemWrite) && !aligned) || (MemRead && MemWrite);
  assign push_entry = '{index: index, data: memWriteData};
  assign wb_empty   = (wb_count == '0);

  // Normal drain: no read in progress and either flushing or full.
  // A simultaneous read+write on a full buffer returns 0 rather than array
  // data, so the head is retired anyway to keep the posted write lossless.
  assign pop = (wb_count != '0) &&
               ((!MemRead && (flush || full)) || (full && push));

  dmem_write_buffer #(.WB_DEPTH(WB_DEPTH)) u_wb (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .pop_entry    (pop_entry),
    .count        (wb_count),
    .lookup_index (index),
    .hit          (hit),
    .hit_data     (hit_data)
  );

  always_comb begin
    memReadData = hit ? hit_data : mem_array[index[IDX_W-1:0]];
    if (bad_access) memReadData = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_array[i] <= '0;
    end else if (pop) begin
      mem_array[pop_entry.index[IDX_W-1:0]] <= pop_entry.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_misaligned <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      if ((MemRead || MemWrite) && !aligned) mem_misaligned <= 1'b1;
      if (MemRead && MemWrite)               proto_err      <= 1'b1;
    end
  end

`ifdef DMEM_STATS_EN
  logic rd_ok;
  assign rd_ok = MemRead && !MemWrite && aligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      fwd_cnt <= '0;
    end else begin
      if (rd_ok)        rd_cnt  <= rd_cnt + 1'b1;
      if (push)         wr_cnt  <= wr_cnt + 1'b1;
      if (rd_ok && hit) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (default build, DEPTH=32, WB_DEPTH=4).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [63:0] memAddr;
  logic [63:0] memWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] memReadData;
  logic        flush;
  logic [2:0]  wb_count;
  logic        wb_empty;
  logic        mem_misaligned;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(32), .WB_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .memAddr        (memAddr),
    .memWriteData   (memWriteData),
    .MemWrite       (MemWrite),
    .MemRead        (MemRead),
    .memReadData    (memReadData),
    .flush          (flush),
    .wb_count       (wb_count),
    .wb_empty       (wb_empty),
    .mem_misaligned (mem_misaligned),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] d,
                       input logic we, input logic re, input logic fl);
    memAddr      = a;
    memWriteData = d;
    MemWrite     = we;
    MemRead      = re;
    flush        = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    #11;
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_count", 64'(wb_count), 64'd0);
    chk("rst_empty", 64'(wb_empty), 64'd1);
    chk("rst_misal", 64'(mem_misaligned), 64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);
    drive(64'h10, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("rst_read10", memReadData, 64'h0);

    // Single write, forwarded read
    drive(64'h8, 64'hAAAA, 1'b1, 1'b0, 1'b0);
    tick();
    drive(64'h8, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("fwd_read8", memReadData, 64'hAAAA);
    chk("fwd_count", 64'(wb_count), 64'd1);
    chk("fwd_array1", dut.mem_array[1], 64'h0);

    // Two writes to the same index: youngest wins, then flush
    drive(64'h20, 64'h1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(64'h20, 64'h2, 1'b1, 1'b0, 1'b0);
    tick();
    drive(64'h20, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("young_read20", memReadData, 64'h2);
    chk("young_count", 64'(wb_count), 64'd3);
    tick();
    chk("read_no_drain", 64'(wb_count), 64'd3);
    drive(64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("flush_step1", 64'(wb_count), 64'd2);
    chk("flush_array1", dut.mem_array[1], 64'hAAAA);
    tick();
    tick();
    chk("flush_empty", 64'(wb_empty), 64'd1);
    chk("flush_array4", dut.mem_array[4], 64'h2);
    drive(64'h0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Five writes: fifth pushes while the oldest drains
    for (int k = 0; k < 5; k++) begin
      drive(64'(8 * k), 64'h100 + 64'(k), 1'b1, 1'b0, 1'b0);
      tick();
      chk("fill_count", 64'(wb_count), (k < 4) ? 64'(k + 1) : 64'd4);
    end
    chk("fill_array0", dut.mem_array[0], 64'h100);
    for (int k = 0; k < 5; k++) begin
      drive(64'(8 * k), 64'h0, 1'b0, 1'b1, 1'b0);
      chk("fill_read", memReadData, 64'h100 + 64'(k));
    end
    drive(64'h100, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("wrap_read100", memReadData, 64'h100);
    tick();
    chk("full_read_hold", 64'(wb_count), 64'd4);
    drive(64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("drain_empty", 64'(wb_empty), 64'd1);
    chk("drain_array4", dut.mem_array[4], 64'h104);

    // Misaligned write is ignored, flag is sticky
    drive(64'hC, 64'h55, 1'b1, 1'b0, 1'b0);
    chk("misal_rdata", memReadData, 64'h0);
    tick();
    chk("misal_count", 64'(wb_count), 64'd0);
    chk("misal_flag", 64'(mem_misaligned), 64'd1);
    drive(64'h8, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("misal_sticky", 64'(mem_misaligned), 64'd1);
    chk("misal_read8", memReadData, 64'h101);

    // Read and write together
    drive(64'h0, 64'h77, 1'b1, 1'b1, 1'b0);
    chk("proto_rdata", memReadData, 64'h0);
    tick();
    chk("proto_flag", 64'(proto_err), 64'd1);
    chk("proto_count", 64'(wb_count), 64'd1);
    drive(64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("proto_read0", memReadData, 64'h77);

    // Asynchronous reset mid-cycle discards pending writes
    drive(64'h8, 64'h88, 1'b1, 1'b0, 1'b0);
    tick();
    drive(64'h10, 64'h99, 1'b1, 1'b0, 1'b0);
    tick();
    drive(64'h10, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_count", 64'(wb_count), 64'd3);
    chk("pre_rst_read10", memReadData, 64'h99);
    #1;
    rst = 1'b0;
    #1;
    chk("async_count", 64'(wb_count), 64'd0);
    chk("async_empty", 64'(wb_empty), 64'd1);
    chk("async_misal", 64'(mem_misaligned), 64'd0);
    chk("async_proto", 64'(proto_err), 64'd0);
    chk("async_read10", memReadData, 64'h0);
    drive(64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("async_read0", memReadData, 64'h0);
    drive(64'h8, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("async_read8", memReadData, 64'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_read8", memReadData, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
